// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and constants for the hybrid branch predictor controller
//
// Purpose: chooser counter encodings, controller FSM states, in-flight entry
//          layout and the chooser training function.
// Ports:   none (package)
package bp_pkg;

  // 2-bit chooser: MSB set selects the global predictor
  localparam logic [1:0] STRONG_LOCAL  = 2'b00;
  localparam logic [1:0] WEAK_LOCAL    = 2'b01;
  localparam logic [1:0] WEAK_GLOBAL   = 2'b10;
  localparam logic [1:0] STRONG_GLOBAL = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_t;

  // Per-branch prediction flags; the address sits above these in a FIFO word
  typedef struct packed {
    logic local_taken;
    logic global_taken;
    logic final_taken;
  } entry_flags_t;

  localparam int FLAGS_W = $bits(entry_flags_t);

  // Move toward whichever predictor alone was right; hold when they agree in outcome
  function automatic logic [1:0] chooser_train(input logic [1:0] cur,
                                               input logic       local_ok,
                                               input logic       global_ok);
    logic [1:0] nxt;
    nxt = cur;
    if (local_ok && !global_ok && cur != STRONG_LOCAL)
      nxt = cur - 2'd1;
    else if (global_ok && !local_ok && cur != STRONG_GLOBAL)
      nxt = cur + 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/hybrid_predict_ctrl_if.sv
// rtl/hybrid_predict_ctrl_if.sv - prediction/resolution bus of the hybrid predictor controller
//
// Purpose: bundles the fetch-side request, resolution-side and predictor-update signals.
// Ports:   master = fetch/resolve stages (drive requests), slave = controller.
interface hybrid_predict_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              Pred_valid;
  logic [ADDR_W-1:0] Pred_addr;
  logic              Local_taken;
  logic              Global_taken;
  logic              Pred_ready;
  logic              Taken;
  logic              Taken_valid;
  logic              Resolve_valid;
  logic              Resolve_taken;
  logic              Flush;
  logic              Upd_valid;
  logic [ADDR_W-1:0] Upd_addr;
  logic              Upd_taken;
  logic              Mispredict;
  logic              Init_busy;

  modport master (
    output Pred_valid, Pred_addr, Local_taken, Global_taken,
    output Resolve_valid, Resolve_taken, Flush,
    input  Pred_ready, Taken, Taken_valid,
    input  Upd_valid, Upd_addr, Upd_taken, Mispredict, Init_busy
  );

  modport slave (
    input  Pred_valid, Pred_addr, Local_taken, Global_taken,
    input  Resolve_valid, Resolve_taken, Flush,
    output Pred_ready, Taken, Taken_valid,
    output Upd_valid, Upd_addr, Upd_taken, Mispredict, Init_busy
  );
endinterface

// File: rtl/bp_inflight_fifo.sv
// rtl/bp_inflight_fifo.sv - in-order FIFO of unresolved predictions
//
// Purpose: synchronous FIFO with push/pop/flush and occupancy count.
// Ports:   clk, rst_n (async active-low), push/wdata, pop/rdata (head, combinational),
//          flush (drops everything still queued after this cycle's pop), count.
module bp_inflight_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 35,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hybrid_predict_ctrl.sv
// rtl/hybrid_predict_ctrl.sv - chooser and in-flight controller of the hybrid branch predictor
//
// Purpose: picks local or global direction per branch from a 2-bit chooser table,
//          queues in-flight predictions, and on each resolution emits one update
//          strobe, trains the chooser and flags mispredictions.
// Ports:   CLK, RESET (async active-low), bus (slave side of hybrid_predict_ctrl_if).
module hybrid_predict_ctrl
  import bp_pkg::*;
#(
  parameter int IDX_W      = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  hybrid_predict_ctrl_if.slave bus
);

  localparam int ENTRY_W = ADDR_W + FLAGS_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  ctrl_state_t      state, state_n;
  logic [IDX_W-1:0] init_cnt, init_cnt_n;
  logic             pred_ready, pop, init_busy;

  logic [1:0]         chooser [2**IDX_W];
  logic [IDX_W-1:0]   pred_idx, head_idx;
  logic               final_taken;
  logic               accept;
  logic               flush_run;
  entry_flags_t       push_flags, head_flags;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [ADDR_W-1:0]  head_addr;
  logic [CNT_W-1:0]   fifo_count;

  logic              taken_q, taken_valid_q, upd_valid_q, upd_taken_q, mispredict_q;
  logic [ADDR_W-1:0] upd_addr_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_n;
      init_cnt <= init_cnt_n;
    end
  end

  // Readiness comes only from the registered count, so a same-cycle pop never frees a slot
  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    init_busy  = 1'b0;
    pred_ready = 1'b0;
    pop        = 1'b0;
    case (state)
      INIT: begin
        init_busy  = 1'b1;
        init_cnt_n = init_cnt + 1'b1;
        if (init_cnt == '1)
          state_n = RUN;
      end
      RUN: begin
        pred_ready = (fifo_count < DEPTH_C) && !bus.Flush;
        pop        = bus.Resolve_valid && (fifo_count != '0);
      end
      default: state_n = INIT;
    endcase
  end

  assign flush_run = (state == RUN) && bus.Flush;
  assign accept    = bus.Pred_valid && pred_ready;

  // Chooser read is combinational on the old table contents, so a same-cycle
  // training write to the same index is not visible to this prediction
  assign pred_idx    = bus.Pred_addr[IDX_W+1:2];
  assign final_taken = chooser[pred_idx][1] ? bus.Global_taken : bus.Local_taken;

  assign push_flags = '{local_taken:  bus.Local_taken,
                        global_taken: bus.Global_taken,
                        final_taken:  final_taken};

  bp_inflight_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET),
    .push  (accept),
    .wdata ({bus.Pred_addr, push_flags}),
    .pop   (pop),
    .flush (flush_run),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  assign head_addr  = fifo_rdata[FLAGS_W +: ADDR_W];
  assign head_flags = entry_flags_t'(fifo_rdata[FLAGS_W-1:0]);
  assign head_idx   = head_addr[IDX_W+1:2];

  // Table holds no reset; the INIT sweep is what establishes its contents
  always_ff @(posedge CLK) begin
    if (state == INIT)
      chooser[init_cnt] <= WEAK_LOCAL;
    else if (pop)
      chooser[head_idx] <= chooser_train(chooser[head_idx],
                                         head_flags.local_taken  == bus.Resolve_taken,
                                         head_flags.global_taken == bus.Resolve_taken);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      taken_q       <= 1'b0;
      taken_valid_q <= 1'b0;
      upd_valid_q   <= 1'b0;
      upd_addr_q    <= '0;
      upd_taken_q   <= 1'b0;
      mispredict_q  <= 1'b0;
    end else begin
      taken_valid_q <= accept;
      if (accept)
        taken_q <= final_taken;
      upd_valid_q <= pop;
      if (pop) begin
        upd_addr_q  <= head_addr;
        upd_taken_q <= bus.Resolve_taken;
      end
      mispredict_q <= pop && (head_flags.final_taken != bus.Resolve_taken);
    end
  end

  assign bus.Pred_ready  = pred_ready;
  assign bus.Init_busy   = init_busy;
  assign bus.Taken       = taken_q;
  assign bus.Taken_valid = taken_valid_q;
  assign bus.Upd_valid   = upd_valid_q;
  assign bus.Upd_addr    = upd_addr_q;
  assign bus.Upd_taken   = upd_taken_q;
  assign bus.Mispredict  = mispredict_q;

endmodule

// File: tb/tb_hybrid_predict_ctrl.sv
// tb/tb_hybrid_predict_ctrl.sv - directed self-checking bench for hybrid_predict_ctrl
module tb_hybrid_predict_ctrl;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  hybrid_predict_ctrl_if #(.ADDR_W(32)) bus ();

  hybrid_predict_ctrl #(
    .IDX_W      (10),
    .FIFO_DEPTH (4),
    .ADDR_W     (32)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Pred_valid    = 1'b0;
    bus.Pred_addr     = '0;
    bus.Local_taken   = 1'b0;
    bus.Global_taken  = 1'b0;
    bus.Resolve_valid = 1'b0;
    bus.Resolve_taken = 1'b0;
    bus.Flush         = 1'b0;
  endtask

  task automatic predict(input logic [31:0] addr, input logic l, input logic g,
                         input logic exp_taken);
    bus.Pred_valid   = 1'b1;
    bus.Pred_addr    = addr;
    bus.Local_taken  = l;
    bus.Global_taken = g;
    #1;
    chk1("pred_ready", bus.Pred_ready, 1'b1);
    tick();
    bus.Pred_valid = 1'b0;
    chk1("taken_valid", bus.Taken_valid, 1'b1);
    chk1("taken", bus.Taken, exp_taken);
  endtask

  task automatic resolve(input logic act, input logic [31:0] exp_addr, input logic exp_misp);
    bus.Resolve_valid = 1'b1;
    bus.Resolve_taken = act;
    tick();
    bus.Resolve_valid = 1'b0;
    chk1("upd_valid", bus.Upd_valid, 1'b1);
    chk32("upd_addr", bus.Upd_addr, exp_addr);
    chk1("upd_taken", bus.Upd_taken, act);
    chk1("mispredict", bus.Mispredict, exp_misp);
  endtask

  // Counts cycles with Init_busy high after reset release; also watches for
  // any ready or update strobe leaking out during the sweep
  task automatic sweep();
    int cycles    = 0;
    int ready_hit = 0;
    int upd_hit   = 0;
    while (bus.Init_busy && cycles < 2000) begin
      if (bus.Pred_ready) ready_hit++;
      tick();
      cycles++;
      if (bus.Upd_valid) upd_hit++;
    end
    chk32("init_cycles", 32'(cycles), 32'd1024);
    chk32("ready_during_init", 32'(ready_hit), 32'd0);
    chk32("upd_during_init", 32'(upd_hit), 32'd0);
  endtask

  initial begin
    RESET = 1'b0;
    idle_inputs();
    #2;
    chk1("rst_init_busy", bus.Init_busy, 1'b1);
    chk1("rst_pred_ready", bus.Pred_ready, 1'b0);
    chk1("rst_taken_valid", bus.Taken_valid, 1'b0);
    chk1("rst_taken", bus.Taken, 1'b0);
    chk1("rst_upd_valid", bus.Upd_valid, 1'b0);
    chk32("rst_upd_addr", bus.Upd_addr, 32'h0);
    chk1("rst_mispredict", bus.Mispredict, 1'b0);
    tick();
    tick();
    RESET = 1'b1;
    sweep();
    chk1("post_init_busy", bus.Init_busy, 1'b0);
    chk1("post_init_ready", bus.Pred_ready, 1'b1);

    // Fresh weak-local entry picks local; a global-right outcome moves it to weak-global
    predict(32'h0040_0010, 1'b1, 1'b0, 1'b1);
    resolve(1'b0, 32'h0040_0010, 1'b1);
    chk1("no_taken_valid_after", bus.Taken_valid, 1'b0);
    predict(32'h0040_0010, 1'b1, 1'b0, 1'b0);
    resolve(1'b0, 32'h0040_0010, 1'b0);

    // Fill to depth, then a push+resolve at full must refuse the push
    for (int i = 0; i < 4; i++)
      predict(32'h0000_0100 + 32'(i * 4), 1'b0, 1'b1, 1'b0);
    bus.Pred_valid    = 1'b1;
    bus.Pred_addr     = 32'h0000_0110;
    bus.Resolve_valid = 1'b1;
    bus.Resolve_taken = 1'b1;
    #1;
    chk1("full_ready", bus.Pred_ready, 1'b0);
    tick();
    idle_inputs();
    chk1("full_taken_valid", bus.Taken_valid, 1'b0);
    chk1("full_upd_valid", bus.Upd_valid, 1'b1);
    chk32("full_upd_addr", bus.Upd_addr, 32'h0000_0100);
    chk1("full_mispredict", bus.Mispredict, 1'b1);
    chk1("ready_after_pop", bus.Pred_ready, 1'b1);

    // Flush with resolve: oldest is still retired, the rest vanish, accept dropped
    bus.Pred_valid    = 1'b1;
    bus.Pred_addr     = 32'h0000_0500;
    bus.Flush         = 1'b1;
    bus.Resolve_valid = 1'b1;
    bus.Resolve_taken = 1'b0;
    #1;
    chk1("flush_ready", bus.Pred_ready, 1'b0);
    tick();
    idle_inputs();
    chk1("flush_upd_valid", bus.Upd_valid, 1'b1);
    chk32("flush_upd_addr", bus.Upd_addr, 32'h0000_0104);
    chk1("flush_mispredict", bus.Mispredict, 1'b0);
    chk1("flush_taken_valid", bus.Taken_valid, 1'b0);
    bus.Resolve_valid = 1'b1;
    tick();
    bus.Resolve_valid = 1'b0;
    chk1("empty_resolve_upd", bus.Upd_valid, 1'b0);
    for (int i = 0; i < 4; i++)
      predict(32'h0000_0200 + 32'(i * 4), 1'b1, 1'b0, 1'b1);
    bus.Pred_valid = 1'b1;
    #1;
    chk1("refill_full_ready", bus.Pred_ready, 1'b0);
    bus.Pred_valid = 1'b0;
    for (int i = 0; i < 4; i++)
      resolve(1'b1, 32'h0000_0200 + 32'(i * 4), 1'b0);

    // Saturation toward global, both-wrong hold, then walk back toward local
    for (int i = 0; i < 5; i++) begin
      predict(32'h0000_0300, 1'b0, 1'b1, (i == 0) ? 1'b0 : 1'b1);
      resolve(1'b1, 32'h0000_0300, (i == 0) ? 1'b1 : 1'b0);
    end
    predict(32'h0000_0300, 1'b1, 1'b1, 1'b1);
    resolve(1'b0, 32'h0000_0300, 1'b1);
    predict(32'h0000_0300, 1'b0, 1'b1, 1'b1);
    resolve(1'b0, 32'h0000_0300, 1'b1);
    predict(32'h0000_0300, 1'b0, 1'b1, 1'b1);
    resolve(1'b0, 32'h0000_0300, 1'b1);
    predict(32'h0000_0300, 1'b0, 1'b1, 1'b0);
    resolve(1'b0, 32'h0000_0300, 1'b0);

    // Mid-run reset with entries in flight
    predict(32'h0000_0400, 1'b1, 1'b0, 1'b1);
    predict(32'h0000_0404, 1'b1, 1'b0, 1'b1);
    RESET = 1'b0;
    #1;
    chk1("mid_rst_taken_valid", bus.Taken_valid, 1'b0);
    chk1("mid_rst_taken", bus.Taken, 1'b0);
    chk1("mid_rst_init_busy", bus.Init_busy, 1'b1);
    chk1("mid_rst_ready", bus.Pred_ready, 1'b0);
    bus.Resolve_valid = 1'b1;
    tick();
    tick();
    RESET = 1'b1;
    sweep();
    tick();
    chk1("stale_upd_valid", bus.Upd_valid, 1'b0);
    chk1("rerun_ready", bus.Pred_ready, 1'b1);
    bus.Resolve_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hybrid_predict_ctrl.md
Name: hybrid_predict_ctrl

Overview:
Controller and chooser for the hybrid branch predictor. It selects between the local and global predictor outputs per branch using a 2-bit chooser table, and tracks in-flight predictions in an in-order FIFO. On each resolution it sequences one update strobe to both predictors, trains the chooser and flags mispredictions. Sits between fetch/decode (prediction requests) and the branch-resolution stage.

Parameters:
IDX_W, 10, chooser index width; table has 2^IDX_W entries indexed by addr[IDX_W+1:2]
FIFO_DEPTH, 4, max in-flight unresolved predictions (power of two)
ADDR_W, 32, instruction address width

Ports:
CLK  input  1  clock
RESET  input  1  asynchronous, active-low reset
Pred_valid  input  1  conditional branch presented this cycle
Pred_addr  input  ADDR_W  branch instruction address
Local_taken  input  1  local predictor direction for Pred_addr
Global_taken  input  1  global predictor direction for Pred_addr
Pred_ready  output  1  request accepted this cycle (RUN and FIFO not full)
Taken  output  1  final registered prediction
Taken_valid  output  1  Taken is valid (one-cycle pulse)
Resolve_valid  input  1  oldest in-flight branch resolved
Resolve_taken  input  1  actual direction
Flush  input  1  discard all in-flight entries
Upd_valid  output  1  update strobe to local/global predictors (one-cycle pulse)
Upd_addr  output  ADDR_W  address to update
Upd_taken  output  1  actual direction to train with
Mispredict  output  1  pulse: popped entry's final prediction != actual
Init_busy  output  1  chooser table initialisation in progress

Behaviour:
- Reset (async, RESET=0): all outputs 0 except Init_busy=1; FIFO pointers/count=0; state=INIT, sweep counter=0.
- FSM INIT: writes chooser[cnt]=2'b01 (weakly local), cnt++ each cycle; after entry 2^IDX_W-1 -> RUN (2^IDX_W cycles). Pred_ready=0, Resolve_valid and Flush ignored in INIT.
- FSM RUN: remains until reset. RESET asserted mid-operation -> INIT, sweep restarts at 0, FIFO contents lost.
- Pred_ready = (state==RUN) && (count<FIFO_DEPTH), from registered count only; a same-cycle pop does not free a slot.
- Accept (Pred_valid && Pred_ready): next cycle Taken = chooser[idx][1] ? Global_taken : Local_taken, Taken_valid=1; push {Pred_addr, Local_taken, Global_taken, final}. Pred_valid while not ready: dropped, Taken_valid=0.
- Resolve (Resolve_valid, RUN, count>0): pop head; next cycle Upd_valid=1, Upd_addr=head addr, Upd_taken=Resolve_taken, Mispredict=(head final != Resolve_taken). Resolve_valid with empty FIFO: ignored, no strobe.
- Chooser training on pop: local correct and global wrong -> decrement, saturate 00; global correct and local wrong -> increment, saturate 11; both correct or both wrong -> unchanged.
- Same-cycle accept and resolve: both occur; count unchanged. If both touch the same chooser index, prediction uses the pre-update value (read-before-write).
- Flush: the same-cycle resolve is processed first (pop, strobe, training). Remaining entries are then cleared (count=0, rd=wr). A same-cycle accept is dropped: Pred_ready is forced 0 when Flush=1.
- Pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.

Decomposition:
- Shared package bp_pkg: chooser-state constants (STRONG_LOCAL=00, WEAK_LOCAL=01, WEAK_GLOBAL=10, STRONG_GLOBAL=11), FSM state encodings INIT/RUN, the in-flight entry struct/width constant.
- One sub-module: bp_inflight_fifo (sync FIFO, parameterised depth/width, push/pop/flush, count).

Test Plan:
- Reset then idle -> Init_busy=1 for exactly 1024 cycles, Pred_ready=0 throughout; then Init_busy=0, Pred_ready=1.
- Addr 0x00400010, Local=1, Global=0, fresh table -> Taken=1 one cycle later. Resolve_taken=0 -> Upd_valid=1, Upd_addr=0x00400010, Mispredict=1, chooser[4]=10. Repeat the branch -> Taken=0.
- Push 4 branches without resolving -> Pred_ready=0 on 5th; same-cycle push+resolve at full -> push refused. Next cycle Pred_ready=1.
- 3 in flight, Flush with Resolve_valid -> one Upd_valid for oldest; count=0. Further Resolve_valid -> no Upd_valid.
- Chooser saturation: 5 resolutions with global correct, local wrong on one addr -> chooser=11 and stays. Both-wrong resolution -> unchanged.
- RESET pulsed low with 2 in flight mid-run -> outputs 0 immediately, Init_busy=1; full 1024-cycle sweep repeats. Old entries never produce Upd_valid.
